// File: rtl/decode_imm_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_imm_stage
//  Purpose  : Registered ID-stage front end. Accepts one instruction per
//             cycle over valid/ready, slices the register fields, builds the
//             sign-extended immediate at XLEN, classifies the format and
//             flags unsupported opcodes. Results appear one cycle later.
//  Ports    : clk, rst (sync, active-high)
//             in_valid / in_ready / in_instr / in_pc   - from IF
//             id_flush                                 - redirect kill
//             out_valid / out_ready                    - to EX handshake
//             out_pc, out_instr, out_opcode, out_rd, out_rs1, out_rs2,
//             out_func3, out_func7, out_imm, out_fmt, out_illegal
//  Params   : XLEN (32 or 64), PC_W
//  Macro    : DECODE_CSR_IMM_EN - CSR*I instructions emit the zero-extended
//             uimm (instr[19:15]) with format code CSR.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_imm_stage #(
   parameter int XLEN = 32,
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   input  logic            id_flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [31:0]     out_instr,
   output logic [6:0]      out_opcode,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [2:0]      out_func3,
   output logic [6:0]      out_func7,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   localparam logic [2:0] c_fmt_r    = 3'd0;
   localparam logic [2:0] c_fmt_i    = 3'd1;
   localparam logic [2:0] c_fmt_s    = 3'd2;
   localparam logic [2:0] c_fmt_b    = 3'd3;
   localparam logic [2:0] c_fmt_u    = 3'd4;
   localparam logic [2:0] c_fmt_j    = 3'd5;
`ifdef DECODE_CSR_IMM_EN
   localparam logic [2:0] c_fmt_csr  = 3'd6;
`endif
   localparam logic [2:0] c_fmt_none = 3'd7;

   localparam logic [6:0] c_op_load   = 7'b0000011;
   localparam logic [6:0] c_op_fence  = 7'b0001111;
   localparam logic [6:0] c_op_imm    = 7'b0010011;
   localparam logic [6:0] c_op_auipc  = 7'b0010111;
   localparam logic [6:0] c_op_imm32  = 7'b0011011;
   localparam logic [6:0] c_op_store  = 7'b0100011;
   localparam logic [6:0] c_op_reg    = 7'b0110011;
   localparam logic [6:0] c_op_lui    = 7'b0110111;
   localparam logic [6:0] c_op_reg32  = 7'b0111011;
   localparam logic [6:0] c_op_branch = 7'b1100011;
   localparam logic [6:0] c_op_jalr   = 7'b1100111;
   localparam logic [6:0] c_op_jal    = 7'b1101111;
   localparam logic [6:0] c_op_system = 7'b1110011;

   localparam bit c_rv64 = (XLEN == 64);

   logic            w_accept;
   logic            w_consume;
   logic [6:0]      w_opcode;
   logic [31:0]     w_imm_i;
   logic [31:0]     w_imm_s;
   logic [31:0]     w_imm_b;
   logic [31:0]     w_imm_j;
   logic [31:0]     w_imm_u;
   logic [31:0]     w_imm32;
   logic [XLEN-1:0] w_imm;
   logic [2:0]      w_fmt;
   logic            w_illegal;

   assign in_ready  = !out_valid || out_ready;
   assign w_accept  = in_valid && in_ready && !id_flush;
   assign w_consume = out_valid && out_ready;

   assign w_opcode = in_instr[6:0];

   // Every immediate fits in 32 bits sign-extended from instr[31]; the
   // XLEN widening is done once below.
   assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
   assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
   assign w_imm_u = {in_instr[31:12], 12'b0};

   // Exact 7-bit opcode matching means any word with instr[1:0] != 2'b11
   // lands in the default branch and is reported illegal.
   always_comb begin
      w_imm32   = 32'd0;
      w_fmt     = c_fmt_none;
      w_illegal = 1'b0;
      case (w_opcode)
         c_op_imm, c_op_load, c_op_jalr, c_op_fence: begin
            w_imm32 = w_imm_i;
            w_fmt   = c_fmt_i;
         end
         c_op_imm32: begin
            if (c_rv64) begin
               w_imm32 = w_imm_i;
               w_fmt   = c_fmt_i;
            end else begin
               w_illegal = 1'b1;
            end
         end
         c_op_store: begin
            w_imm32 = w_imm_s;
            w_fmt   = c_fmt_s;
         end
         c_op_branch: begin
            w_imm32 = w_imm_b;
            w_fmt   = c_fmt_b;
         end
         c_op_jal: begin
            w_imm32 = w_imm_j;
            w_fmt   = c_fmt_j;
         end
         c_op_lui, c_op_auipc: begin
            w_imm32 = w_imm_u;
            w_fmt   = c_fmt_u;
         end
         c_op_reg: begin
            w_fmt = c_fmt_r;
         end
         c_op_reg32: begin
            if (c_rv64) begin
               w_fmt = c_fmt_r;
            end else begin
               w_illegal = 1'b1;
            end
         end
         c_op_system: begin
`ifdef DECODE_CSR_IMM_EN
            // func3[2] selects the immediate-operand CSR forms (uimm in rs1).
            if (in_instr[14]) begin
               w_imm32 = {27'd0, in_instr[19:15]};
               w_fmt   = c_fmt_csr;
            end else begin
               w_imm32 = w_imm_i;
               w_fmt   = c_fmt_i;
            end
`else
            w_imm32 = w_imm_i;
            w_fmt   = c_fmt_i;
`endif
         end
         default: begin
            w_illegal = 1'b1;
         end
      endcase
   end

   generate
      if (XLEN > 32) begin : g_imm_wide
         assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
      end else begin : g_imm_narrow
         assign w_imm = w_imm32[XLEN-1:0];
      end
   endgenerate

   // Flush shares the reset path: both leave a bubble with cleared data.
   always_ff @(posedge clk) begin
      if (rst || id_flush) begin
         out_valid   <= 1'b0;
         out_pc      <= '0;
         out_instr   <= '0;
         out_opcode  <= '0;
         out_rd      <= '0;
         out_rs1     <= '0;
         out_rs2     <= '0;
         out_func3   <= '0;
         out_func7   <= '0;
         out_imm     <= '0;
         out_fmt     <= c_fmt_none;
         out_illegal <= 1'b0;
      end else if (w_accept) begin
         out_valid   <= 1'b1;
         out_pc      <= in_pc;
         out_instr   <= in_instr;
         out_opcode  <= in_instr[6:0];
         out_rd      <= in_instr[11:7];
         out_rs1     <= in_instr[19:15];
         out_rs2     <= in_instr[24:20];
         out_func3   <= in_instr[14:12];
         out_func7   <= in_instr[31:25];
         out_imm     <= w_imm;
         out_fmt     <= w_fmt;
         out_illegal <= w_illegal;
      end else if (w_consume) begin
         out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_decode_imm_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_imm_stage
//  Purpose  : Self-checking bench for decode_imm_stage. A behavioural model
//             of the stage contents is compared with the DUT every cycle;
//             directed vectors add literal expectations.
//  Macro    : DECODE_CSR_IMM_EN selects the expected CSR immediate behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_imm_stage;

   localparam int XLEN = 32;
   localparam int PC_W = 32;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [PC_W-1:0] in_pc;
   logic            id_flush;
   logic            out_valid;
   logic            out_ready;
   logic [PC_W-1:0] out_pc;
   logic [31:0]     out_instr;
   logic [6:0]      out_opcode;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [2:0]      out_func3;
   logic [6:0]      out_func7;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_fmt;
   logic            out_illegal;

   decode_imm_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .in_pc      (in_pc),
      .id_flush   (id_flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_pc     (out_pc),
      .out_instr  (out_instr),
      .out_opcode (out_opcode),
      .out_rd     (out_rd),
      .out_rs1    (out_rs1),
      .out_rs2    (out_rs2),
      .out_func3  (out_func3),
      .out_func7  (out_func7),
      .out_imm    (out_imm),
      .out_fmt    (out_fmt),
      .out_illegal(out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;
   logic [PC_W-1:0] pc = '0;

   // Model state: what the stage holds after each edge.
   bit              m_valid = 1'b0;
   bit              m_empty = 1'b1;
   logic [31:0]     m_instr = '0;
   logic [PC_W-1:0] m_pc    = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
      logic [63:0] m;
      logic [63:0] x;
      m = 64'd1 << (bits - 1);
      x = v & ((m << 1) - 64'd1);
      return (x ^ m) - m;
   endfunction

   // Immediate/format/illegal as the instruction-set rules define them.
   function automatic void model(input logic [31:0] ins, output logic [63:0] imm,
                                 output logic [2:0] fmt, output logic ill);
      logic [63:0] w;
      w   = 64'(ins);
      imm = 64'd0;
      fmt = 3'd7;
      ill = 1'b0;
      case (ins[6:0])
         7'h13, 7'h03, 7'h67, 7'h0F: begin fmt = 3'd1; imm = sext(w >> 20, 12); end
         7'h1B: if (XLEN == 64) begin fmt = 3'd1; imm = sext(w >> 20, 12); end
                else ill = 1'b1;
         7'h23: begin
            fmt = 3'd2;
            imm = sext(((w >> 25) << 5) | ((w >> 7) & 64'h1F), 12);
         end
         7'h63: begin
            fmt = 3'd3;
            imm = sext(((w >> 31) << 12) | (((w >> 7) & 64'h1) << 11) |
                       (((w >> 25) & 64'h3F) << 5) | (((w >> 8) & 64'hF) << 1), 13);
         end
         7'h6F: begin
            fmt = 3'd5;
            imm = sext(((w >> 31) << 20) | (((w >> 12) & 64'hFF) << 12) |
                       (((w >> 20) & 64'h1) << 11) | (((w >> 21) & 64'h3FF) << 1), 21);
         end
         7'h37, 7'h17: begin fmt = 3'd4; imm = sext(w & 64'hFFFF_F000, 32); end
         7'h33: fmt = 3'd0;
         7'h3B: if (XLEN == 64) fmt = 3'd0;
                else ill = 1'b1;
         7'h73: begin
`ifdef DECODE_CSR_IMM_EN
            if (((w >> 12) & 64'h4) != 64'd0) begin
               fmt = 3'd6;
               imm = (w >> 15) & 64'h1F;
            end else begin
               fmt = 3'd1;
               imm = sext(w >> 20, 12);
            end
`else
            fmt = 3'd1;
            imm = sext(w >> 20, 12);
`endif
         end
         default: ill = 1'b1;
      endcase
      if (ins[1:0] != 2'b11) begin
         ill = 1'b1;
         fmt = 3'd7;
         imm = 64'd0;
      end
   endfunction

   always @(posedge clk) begin
      if (rst || id_flush) begin
         m_valid = 1'b0;
         m_empty = 1'b1;
      end else if (in_valid && (!m_valid || out_ready)) begin
         m_valid = 1'b1;
         m_empty = 1'b0;
         m_instr = in_instr;
         m_pc    = in_pc;
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
   end

   always @(negedge clk) begin
      logic [63:0]     e_imm64;
      logic [XLEN-1:0] e_imm;
      logic [2:0]      e_fmt;
      logic            e_ill;
      logic [31:0]     e_ins;
      logic [PC_W-1:0] e_pc;
      if (chk_en) begin
         model(m_instr, e_imm64, e_fmt, e_ill);
         e_ins = m_instr;
         e_pc  = m_pc;
         if (m_empty) begin
            e_imm64 = 64'd0;
            e_fmt   = 3'd7;
            e_ill   = 1'b0;
            e_ins   = 32'd0;
            e_pc    = '0;
         end
         e_imm = e_imm64[XLEN-1:0];
         chk("out_valid", 64'(out_valid), 64'(m_valid));
         chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
         chk("out_pc", 64'(out_pc), 64'(e_pc));
         chk("out_instr", 64'(out_instr), 64'(e_ins));
         chk("out_opcode", 64'(out_opcode), 64'(e_ins[6:0]));
         chk("out_rd", 64'(out_rd), 64'(e_ins[11:7]));
         chk("out_rs1", 64'(out_rs1), 64'(e_ins[19:15]));
         chk("out_rs2", 64'(out_rs2), 64'(e_ins[24:20]));
         chk("out_func3", 64'(out_func3), 64'(e_ins[14:12]));
         chk("out_func7", 64'(out_func7), 64'(e_ins[31:25]));
         chk("out_imm", 64'(out_imm), 64'(e_imm));
         chk("out_fmt", 64'(out_fmt), 64'(e_fmt));
         chk("out_illegal", 64'(out_illegal), 64'(e_ill));
      end
   end

   task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
      in_valid  = v;
      in_instr  = ins;
      in_pc     = pc;
      pc        = pc + 4;
      out_ready = ordy;
      id_flush  = fl;
      @(posedge clk);
      #1;
   endtask

   localparam logic [63:0] c_lui_exp = (XLEN == 64) ? 64'hFFFF_FFFF_8000_0000
                                                    : 64'h0000_0000_8000_0000;

   initial begin
      logic [XLEN-1:0] lui_exp;
      lui_exp   = c_lui_exp[XLEN-1:0];
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      id_flush  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      step(1'b1, 32'h00100093, 1'b1, 1'b0);   // offered during reset, dropped
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_fmt", 64'(out_fmt), 64'd7);
      chk("rst_imm", 64'(out_imm), 64'd0);
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // ADDI x1,x0,-1
      step(1'b1, 32'hFFF00093, 1'b1, 1'b0);
      chk("addi_imm", 64'(out_imm), 64'(32'hFFFF_FFFF));
      chk("addi_rd", 64'(out_rd), 64'd1);
      chk("addi_fmt", 64'(out_fmt), 64'd1);
      chk("addi_ill", 64'(out_illegal), 64'd0);

      // SW then BEQ back-to-back
      step(1'b1, 32'h00112623, 1'b1, 1'b0);
      chk("sw_imm", 64'(out_imm), 64'h0000_000C);
      chk("sw_fmt", 64'(out_fmt), 64'd2);
      chk("sw_valid", 64'(out_valid), 64'd1);
      step(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
      chk("beq_imm", 64'(out_imm), 64'(32'hFFFF_FFFC));
      chk("beq_fmt", 64'(out_fmt), 64'd3);
      chk("beq_valid", 64'(out_valid), 64'd1);

      // LUI x5,0x80000
      step(1'b1, 32'h800002B7, 1'b1, 1'b0);
      chk("lui_imm", 64'(out_imm), 64'(lui_exp));
      chk("lui_fmt", 64'(out_fmt), 64'd4);

      // JAL x1,8 and ADD
      step(1'b1, 32'h008000EF, 1'b1, 1'b0);
      chk("jal_imm", 64'(out_imm), 64'd8);
      chk("jal_fmt", 64'(out_fmt), 64'd5);
      step(1'b1, 32'h002081B3, 1'b1, 1'b0);
      chk("add_fmt", 64'(out_fmt), 64'd0);
      chk("add_imm", 64'(out_imm), 64'd0);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // Backpressure
      step(1'b1, 32'h00500113, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 32'h00A00193, 1'b0, 1'b0);
         chk("bp_instr", 64'(out_instr), 64'(32'h00500113));
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_valid", 64'(out_valid), 64'd1);
      end
      step(1'b1, 32'h00A00193, 1'b1, 1'b0);
      chk("bp_next", 64'(out_instr), 64'(32'h00A00193));
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("bp_drain", 64'(out_valid), 64'd0);

      // Flush while holding, with out_ready low
      step(1'b1, 32'h00700213, 1'b0, 1'b0);
      chk("fl_pre", 64'(out_valid), 64'd1);
      step(1'b1, 32'h00100093, 1'b0, 1'b1);
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_imm", 64'(out_imm), 64'd0);
      chk("fl_fmt", 64'(out_fmt), 64'd7);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("fl_dropped", 64'(out_valid), 64'd0);

      // CSRRWI x0,0x300,5
      step(1'b1, 32'h3002D073, 1'b1, 1'b0);
`ifdef DECODE_CSR_IMM_EN
      chk("csr_imm", 64'(out_imm), 64'd5);
      chk("csr_fmt", 64'(out_fmt), 64'd6);
`else
      chk("csr_imm", 64'(out_imm), 64'h300);
      chk("csr_fmt", 64'(out_fmt), 64'd1);
`endif
      // CSRRW x0,0x300,x5 (register form)
      step(1'b1, 32'h30029073, 1'b1, 1'b0);
      chk("csrrw_fmt", 64'(out_fmt), 64'd1);

      // Illegal encodings
      step(1'b1, 32'h0000007F, 1'b1, 1'b0);
      chk("ill_flag", 64'(out_illegal), 64'd1);
      chk("ill_fmt", 64'(out_fmt), 64'd7);
      step(1'b1, 32'h00000012, 1'b1, 1'b0);
      chk("ill_lowbits", 64'(out_illegal), 64'd1);
      step(1'b1, 32'h0000003B, 1'b1, 1'b0);
      chk("ill_rv64op", 64'(out_illegal), 64'(XLEN != 64));

      // Reset mid-handshake
      step(1'b1, 32'h00500113, 1'b0, 1'b0);
      rst = 1'b1;
      step(1'b1, 32'h00A00193, 1'b1, 1'b0);
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_fmt", 64'(out_fmt), 64'd7);
      rst = 1'b0;
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b1, 32'h00A00193, 1'b1, 1'b0);
      chk("post_rst", 64'(out_instr), 64'(32'h00A00193));
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/decode_imm_stage.md
# decode_imm_stage

Registered ID-stage front end for the integer pipeline. It accepts one fetched instruction per cycle over a valid/ready handshake and splits out the register fields. It also generates the sign-extended immediate at a parametrised XLEN and classifies the instruction format. Results are presented one cycle later to the execute/hazard logic. It replaces the purely combinational immediate generator and adds buffering, backpressure, flush-to-bubble and illegal-opcode detection.

## Interface
- `XLEN`, 32, datapath and immediate width; legal values are 32 and 64.
- `PC_W`, 32, width of the PC carried alongside the instruction.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  IF stage offers an instruction.
- `in_ready`  out  1  stage can accept; combinational, `!out_valid || out_ready`.
- `in_instr`  in  32  raw instruction word.
- `in_pc`  in  PC_W  PC of `in_instr`.
- `id_flush`  in  1  kill the held and incoming instruction (branch/trap redirect).
- `out_valid`  out  1  decoded instruction available.
- `out_ready`  in  1  EX stage consumes the instruction this cycle.
- `out_pc`  out  PC_W  registered PC.
- `out_instr`  out  32  registered instruction word.
- `out_opcode`  out  7; `out_rd`, `out_rs1`, `out_rs2`  out  5 each; `out_func3`  out  3; `out_func7`  out  7.
- `out_imm`  out  XLEN  sign-extended immediate.
- `out_fmt`  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, CSR=6, NONE=7.
- `out_illegal`  out  1  the opcode is unsupported, or `instr[1:0]` is not 2'b11.

## Operation
- Accept condition: `in_valid && in_ready && !id_flush`. On accept, all `out_*` data registers load the decode of `in_instr`, and `out_valid` is set to 1.
- Consume condition: `out_valid && out_ready`. If consume occurs without a simultaneous accept, `out_valid` is cleared to 0.
- Simultaneous consume and accept: the stage reloads in the same cycle and `out_valid` stays 1. This gives full throughput.
- When `out_valid=1` and `out_ready=0`, all outputs hold stable and `in_ready=0`.
- `id_flush=1` takes priority over everything else:
  - next cycle `out_valid=0`;
  - all data outputs are zero, except that `out_fmt` is NONE and `out_illegal` is 0;
  - any instruction offered in that cycle is dropped.
- Immediate rules. Each is sign-extended from its top bit, `instr[31]`, to XLEN:
  - I-type, for opcodes 0010011, 0000011 and 1100111 (and 0011011 when XLEN=64): `instr[31:20]`.
  - S-type (0100011): `{instr[31:25], instr[11:7]}`.
  - B-type (1100011): `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
  - J-type (1101111): `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
  - U-type (0110111, 0010111): `{instr[31:12], 12'b0}`. This is sign-extended above bit 31 when XLEN=64.
  - R-type (0110011, plus 0111011 when XLEN=64) gives imm 0, fmt R.
  - FENCE (0001111) gives I-type.
  - SYSTEM (1110011): see Configuration.
  - Any other opcode gives imm 0, fmt NONE, `out_illegal=1`.
- Field outputs are raw bit slices and are valid for every format.

## Timing
- Latency is 1 cycle from accept to `out_valid`. Throughput is 1 instruction per cycle while `out_ready=1`.
- `in_ready` depends combinationally on `out_ready`. There are no other combinational input-to-output paths; all `out_*` signals are registered.
- Reset values: `out_valid=0` and all data outputs 0, except `out_fmt`=NONE (7) and `out_illegal=0`. `in_ready=1` in the first cycle after reset.
- Reset mid-handshake discards the held instruction. Reset overrides flush and accept.
- Flush and `out_ready=0` together: the flush still empties the stage next cycle.

## Configuration
- Macro: `DECODE_CSR_IMM_EN`.
- Defined: SYSTEM instructions with `func3[2]=1` (CSRRWI/CSRRSI/CSRRCI) produce `out_imm` = zero-extended `instr[19:15]` and `out_fmt`=CSR. SYSTEM instructions with `func3[2]=0` produce an I-type immediate (the CSR address, sign-extended).
- Undefined: all SYSTEM instructions produce an I-type immediate and fmt I. Format code 6 is never emitted.

## Test plan
- ADDI x1,x0,-1 (0xFFF00093), out_ready=1 → next cycle `out_imm`=0xFFFFFFFF, rd=1, fmt=I, illegal=0.
- SW x1,12(x2) (0x00112623) followed back-to-back by BEQ x0,x0,-4 (0xFE000EE3):
  - first instruction: imm=0x0000000C, fmt=S;
  - next cycle: imm=0xFFFFFFFC, fmt=B;
  - `out_valid` stays high throughout.
- LUI x5,0x80000 (0x800002B7) → imm=0x80000000 at XLEN=32 and 0xFFFFFFFF80000000 at XLEN=64; fmt=U.
- Backpressure: load 0x00500113, then hold out_ready=0 for 3 cycles while in_valid=1 offers 0x00A00193:
  - `in_ready=0` and outputs are unchanged for those 3 cycles;
  - releasing out_ready yields 0x00500113, then 0x00A00193 on the next cycle, with nothing lost or duplicated.
- Flush: with out_valid=1, assert id_flush together with in_valid=1 (0x00100093) → next cycle out_valid=0 and imm=0; the offered instruction never appears.
- CSRRWI x0,0x300,5 (0x3002D073) → with `DECODE_CSR_IMM_EN` defined: imm=5, fmt=CSR; without it: imm=0x300, fmt=I. Opcode 0x0000007F → illegal=1, fmt=NONE.
